// File: rtl/param_icache_pkg.sv
// Shared types and helpers for the parametrised instruction cache.
package param_icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  // Tag width left after removing the index, the word offset and the byte offset.
  function automatic int tag_width(input int nsets, input int words);
    return 32 - $clog2(nsets) - $clog2(words) - 2;
  endfunction

endpackage

// File: rtl/param_icache_array.sv
// Valid/tag/data storage for the direct-mapped icache.
// There is one data write port, used for each fill beat, and one line write port that commits
// the tag and sets valid. The read port is combinational.
module param_icache_array
  import param_icache_pkg::*;
#(
  parameter int NSETS = 8,
  parameter int WORDS = 2,
  parameter int TAG_W = 26,
  localparam int IDX_W = $clog2(NSETS),
  localparam int OFF_W = $clog2(WORDS),
  localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_valid,
  input  logic              data_we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_WS-1:0] wr_off,
  input  logic [31:0]       wr_data,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_WS-1:0] rd_off,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_data
);

  localparam int AW = IDX_W + OFF_W;

  logic [NSETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [NSETS];
  logic [TAG_W-1:0] tag_d  [NSETS];
  logic [31:0]      data_q [NSETS*WORDS];
  logic [31:0]      data_d [NSETS*WORDS];
  logic [AW-1:0]    wr_addr, rd_addr;

  if (OFF_W > 0) begin : g_off
    assign wr_addr = {wr_idx, wr_off};
    assign rd_addr = {rd_idx, rd_off};
  end else begin : g_nooff
    logic unused_off;
    assign unused_off = ^{wr_off, rd_off};
    assign wr_addr = wr_idx;
    assign rd_addr = rd_idx;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_addr];

  // Next storage contents. A whole-cache clear wins over a line commit in the same cycle.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (data_we) data_d[wr_addr] = wr_data;
    if (line_we) begin
      tag_d[wr_idx]   = wr_tag;
      valid_d[wr_idx] = 1'b1;
    end
    if (clr_valid) valid_d = '0;
  end

  // Only the valid bits are reset; tags and data are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/param_icache.sv
// Parametrised direct-mapped read-only instruction cache with multi-word blocks.
// Hits are served combinationally. A miss fills the whole block, one word per memory beat.
// Define PARAM_ICACHE_STATS_EN to build the hit and miss counters. Otherwise both outputs read 0.
module param_icache
  import param_icache_pkg::*;
#(
  parameter int NSETS = 8,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        inv,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W  = $clog2(NSETS);
  localparam int OFF_W  = $clog2(WORDS);
  localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1;
  localparam int TAG_W  = tag_width(NSETS, WORDS);
  localparam logic [OFF_WS-1:0] LAST_BEAT = OFF_WS'(WORDS - 1);

  // The low field carries the word offset and the byte offset together, so it exists even when WORDS is 1.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W+1:0] lo;
  } addr_split_t;

  addr_split_t       req;
  logic [OFF_WS-1:0] req_off;

  icache_state_t     state_q, state_d;
  logic [OFF_WS-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;

  logic              data_we, line_we, miss_start;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic [31:0]       fill_addr;

  assign req     = addr_split_t'(imemaddr);
  assign req_off = OFF_WS'(req.lo >> 2);

  if (OFF_W > 0) begin : g_off
    assign fill_addr = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
  end else begin : g_nooff
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
    assign fill_addr  = {miss_tag_q, miss_idx_q, 2'b00};
  end

  // Array writes are held off during reset, so a fill that reset interrupts leaves no tag or valid state.
  param_icache_array #(
    .NSETS(NSETS),
    .WORDS(WORDS),
    .TAG_W(TAG_W)
  ) u_array (
    .clk      (CLK),
    .rst      (RST),
    .clr_valid(inv),
    .data_we  (data_we & ~RST),
    .wr_idx   (miss_idx_q),
    .wr_off   (cnt_q),
    .wr_data  (iload),
    .line_we  (line_we & ~RST),
    .wr_tag   (miss_tag_q),
    .rd_idx   (req.idx),
    .rd_off   (req_off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  // Hit detection, miss capture and fill sequencing. inv aborts a fill in progress.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    data_we    = 1'b0;
    line_we    = 1'b0;
    miss_start = 1'b0;
    case (state_q)
      IDLE: begin
        ihit = imemREN & rd_valid & (rd_tag == req.tag) & ~inv;
        if (ihit) imemload = rd_data;
        if (imemREN & ~ihit & ~inv) begin
          miss_tag_d = req.tag;
          miss_idx_d = req.idx;
          cnt_d      = '0;
          miss_start = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = fill_addr;
        if (inv) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!iwait) begin
          data_we = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            line_we = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, beat counter and miss address registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

`ifdef PARAM_ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Count hit cycles and fill starts. Both wrap modulo 2^32, and inv leaves them untouched.
  always_comb begin
    hit_count_d  = hit_count_q + {31'd0, ihit};
    miss_count_d = miss_count_q + {31'd0, miss_start};
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_miss_start;
  assign unused_miss_start = miss_start;
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_param_icache.sv
// Directed testbench for param_icache with NSETS=8 and WORDS=2.
// The memory model holds iwait high for two cycles before each beat.
module tb_param_icache;

`ifdef PARAM_ICACHE_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        RST, imemREN, inv, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr, hit_count, miss_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] beat_q[$];

  param_icache #(.NSETS(8), .WORDS(2)) dut (
    .CLK       (clk),
    .RST       (RST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .inv       (inv),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h40:  return 32'hAAAA_0000;
      32'h44:  return 32'hBBBB_0000;
      default: return 32'hC0DE_0000 | {16'd0, a[15:0]};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues a fetch and counts the sampled cycles until the first ihit. Latency 0 means a same-cycle hit.
  task automatic fetch(input logic [31:0] addr, input int exp_lat,
                       input logic [31:0] exp_data, input string name);
    int n = 0;
    imemREN  = 1'b1;
    imemaddr = addr;
    forever begin
      @(negedge clk);
      if (ihit || n >= 40) break;
      n++;
      @(posedge clk); #1;
    end
    check({name, "_lat"}, n, exp_lat);
    check({name, "_data"}, imemload, exp_data);
    @(posedge clk); #1;
    imemREN = 1'b0;
  endtask

  // Memory responder: two busy cycles, then one beat with iwait low. Each granted address is logged.
  initial begin
    int ctr;
    ctr   = 0;
    iwait = 1'b1;
    iload = '0;
    forever begin
      @(negedge clk);
      if (iREN) begin
        if (ctr < 2) begin
          iwait = 1'b1;
          iload = '0;
          ctr++;
        end else begin
          iwait = 1'b0;
          iload = mem_word(iaddr);
          beat_q.push_back(iaddr);
          ctr = 0;
        end
      end else begin
        iwait = 1'b1;
        iload = '0;
        ctr   = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; inv = 1'b0;
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;
    @(negedge clk);
    check("rst_ihit", ihit, 0);
    check("rst_iren", iREN, 0);
    check("rst_iaddr", iaddr, 0);
    check("rst_imemload", imemload, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
    @(posedge clk); #1;

    // Cold miss on 0x40.
    beat_q.delete();
    fetch(32'h40, 7, 32'hAAAA_0000, "cold");
    check("cold_beats", beat_q.size(), 2);
    if (beat_q.size() == 2) begin
      check("cold_beat0", beat_q[0], 32'h40);
      check("cold_beat1", beat_q[1], 32'h44);
    end

    // Nine more hit cycles, which makes ten in total.
    imemREN = 1'b1; imemaddr = 32'h40;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("stream_hit", ihit, 1);
      @(posedge clk); #1;
    end
    imemREN = 1'b0;
    @(negedge clk);
    check("stats_hits10", hit_count, 32'(10 * STATS));
    check("stats_miss1", miss_count, 32'(1 * STATS));
    @(posedge clk); #1;

    fetch(32'h44, 0, 32'hBBBB_0000, "hit44");

    // Conflict misses on set 0.
    beat_q.delete();
    fetch(32'h80, 7, 32'hC0DE_0080, "conf80");
    check("conf_beats", beat_q.size(), 2);
    if (beat_q.size() == 2) begin
      check("conf_beat0", beat_q[0], 32'h80);
      check("conf_beat1", beat_q[1], 32'h84);
    end
    fetch(32'h84, 0, 32'hC0DE_0084, "hit84");
    fetch(32'h40, 7, 32'hAAAA_0000, "conf40");
    @(negedge clk);
    check("conf_misses", miss_count, 32'(3 * STATS));
    check("conf_hits", hit_count, 32'(14 * STATS));
    @(posedge clk); #1;

    // Invalidate while 0x40 is cached.
    imemREN = 1'b1; imemaddr = 32'h40; inv = 1'b1;
    @(negedge clk);
    check("inv_hit_suppressed", ihit, 0);
    @(posedge clk); #1;
    inv = 1'b0; imemREN = 1'b0;
    @(negedge clk);
    check("inv_no_fill", iREN, 0);
    @(posedge clk); #1;
    fetch(32'h40, 7, 32'hAAAA_0000, "inv_refetch");

    // Invalidate during the second beat of a fill.
    beat_q.delete();
    imemREN = 1'b1; imemaddr = 32'h100;
    n = 0;
    while (beat_q.size() == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("abort_first_beat", beat_q.size(), 1);
    @(posedge clk); #1;
    imemREN = 1'b0; inv = 1'b1;
    @(negedge clk);
    check("abort_in_fill", iREN, 1);
    @(posedge clk); #1;
    inv = 1'b0;
    @(negedge clk);
    check("abort_idle", iREN, 0);
    @(posedge clk); #1;
    fetch(32'h100, 7, 32'hC0DE_0100, "abort_refetch");

    // Changing the address during a fill does not redirect it.
    beat_q.delete();
    imemREN = 1'b1; imemaddr = 32'h40;
    @(posedge clk); #1;
    imemaddr = 32'h100;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (iREN && n < 40);
    check("chg_fill_len", n, 7);
    check("chg_nohit", ihit, 0);
    imemREN = 1'b0;
    check("chg_beats", beat_q.size(), 2);
    if (beat_q.size() == 2) begin
      check("chg_beat0", beat_q[0], 32'h40);
      check("chg_beat1", beat_q[1], 32'h44);
    end
    @(posedge clk); #1;
    fetch(32'h100, 7, 32'hC0DE_0100, "chg_miss100");

    // Reset in the middle of a fill.
    imemREN = 1'b1; imemaddr = 32'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    RST = 1'b1; imemREN = 1'b0;
    @(negedge clk);
    check("rstfill_busy", iREN, 1);
    @(posedge clk); #1;
    RST = 1'b0;
    @(negedge clk);
    check("rstfill_iren", iREN, 0);
    check("rstfill_iaddr", iaddr, 0);
    check("rstfill_hits", hit_count, 0);
    check("rstfill_misses", miss_count, 0);
    @(posedge clk); #1;
    fetch(32'h100, 7, 32'hC0DE_0100, "rstfill_refetch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
